// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// ex_muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply / divide / multiply-accumulate engine for the EX stage.
// It retires one operand bit per clock and returns a 2*WIDTH {HI,LO} result.
// While it is working it holds the EX stage through stallreq_o.
//
//   Ops (op_i): 000 MULT, 001 MULTU, 010 MADD, 011 MADDU,
//               100 MSUB, 101 MSUBU, 110 DIV,  111 DIVU
//
// Flow: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
// A divide by zero skips straight from IDLE to DONE.
//
// Parameters
//   WIDTH   operand width; result_o is 2*WIDTH bits
//   ACC_EN  1: MADD/MSUB accumulate into hilo; 0: they behave as MULT/MULTU
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start_i        request, sampled only in IDLE
//   op_i           operation code (see table above)
//   opa_i          multiplicand / dividend
//   opb_i          multiplier / divisor
//   hilo_i         current {HI,LO} for the accumulate ops
//   annul_i        abort; wins over everything except rst
//   busy_o         engine not idle
//   stallreq_o     combinational stall request toward the EX stage
//   done_o         one-cycle pulse; result_o is valid
//   result_o       {HI,LO}; for divides {remainder, quotient}; held until next done
//   div_by_zero_o  valid with done_o; set only for DIV/DIVU by zero
// ============================================================================
module ex_muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 stallreq_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Operation decode of the incoming request
    // ------------------------------------------------------------------
    logic             start_ok;
    logic             in_signed;
    logic             in_div;
    logic             in_acc_add;
    logic             in_acc_sub;
    logic             in_div_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign start_ok    = (state_reg == S_IDLE) && start_i && !annul_i;
    assign in_signed   = ~op_i[0];
    assign in_div      = (op_i[2:1] == 2'b11);
    assign in_acc_add  = ACC_EN && (op_i[2:1] == 2'b01);
    assign in_acc_sub  = ACC_EN && (op_i[2:1] == 2'b10);
    assign in_div_zero = in_div && (opb_i == '0);

    // Magnitudes are taken as unsigned WIDTH-bit values, so the most
    // negative number maps onto itself and is still the correct magnitude.
    assign abs_a = (in_signed && opa_i[WIDTH-1]) ? (~opa_i + WIDTH'(1)) : opa_i;
    assign abs_b = (in_signed && opb_i[WIDTH-1]) ? (~opb_i + WIDTH'(1)) : opb_i;

    // ------------------------------------------------------------------
    // Operation context latched at start
    // ------------------------------------------------------------------
    logic             is_signed_reg;
    logic             is_div_reg;
    logic             acc_add_reg;
    logic             acc_sub_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic [DW-1:0]    hilo_reg;
    logic [CNT_W-1:0] count_reg;

    // Multiplier datapath: product accumulates the shifted multiplicand
    // whenever the current low multiplier bit is set.
    logic [DW-1:0]    prod_reg;
    logic [DW-1:0]    mcand_reg;
    logic [WIDTH-1:0] mplier_reg;

    // Divider datapath: {rem,quot} shift left; quot starts as the dividend.
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] divisor_reg;

    logic [DW-1:0]    result_reg;
    logic             dbz_reg;

    // ------------------------------------------------------------------
    // One multiply step: gate the multiplicand by the current multiplier bit
    // ------------------------------------------------------------------
    logic [DW-1:0] addend;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // One restoring-divide step
    // ------------------------------------------------------------------
    // rem_reg is always below the divisor, so the shifted value needs one
    // extra bit but the difference after a successful subtract fits WIDTH.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;

    assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});

    // ------------------------------------------------------------------
    // Sign fix-up and accumulate (all arithmetic mod 2^DW)
    // ------------------------------------------------------------------
    logic [DW-1:0]    mul_signed;
    logic [DW-1:0]    mul_result;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [DW-1:0]    fix_result;
    logic             neg_result;

    always_comb begin
        neg_result = is_signed_reg && (sign_a_reg ^ sign_b_reg);

        mul_signed = neg_result ? (~prod_reg + DW'(1)) : prod_reg;
        mul_result = mul_signed;
        if (acc_add_reg) begin
            mul_result = hilo_reg + mul_signed;
        end else if (acc_sub_reg) begin
            mul_result = hilo_reg - mul_signed;
        end

        // Quotient follows the sign rule; remainder follows the dividend.
        quot_fix = neg_result ? (~quot_reg + WIDTH'(1)) : quot_reg;
        rem_fix  = (is_signed_reg && sign_a_reg) ? (~rem_reg + WIDTH'(1)) : rem_reg;

        fix_result = is_div_reg ? {rem_fix, quot_fix} : mul_result;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        busy_o     = (state_reg != S_IDLE);
        done_o     = (state_reg == S_DONE);
        stallreq_o = start_ok || (state_reg == S_CALC) || (state_reg == S_FIX);

        if (annul_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        state_next = in_div_zero ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (count_reg == CNT_LAST) begin
                        state_next = S_FIX;
                    end
                end
                S_FIX:   state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            is_signed_reg <= 1'b0;
            is_div_reg    <= 1'b0;
            acc_add_reg   <= 1'b0;
            acc_sub_reg   <= 1'b0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
            hilo_reg      <= '0;
            count_reg     <= '0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
            result_reg    <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        is_signed_reg <= in_signed;
                        is_div_reg    <= in_div;
                        acc_add_reg   <= in_acc_add;
                        acc_sub_reg   <= in_acc_sub;
                        sign_a_reg    <= in_signed && opa_i[WIDTH-1];
                        sign_b_reg    <= in_signed && opb_i[WIDTH-1];
                        hilo_reg      <= hilo_i;
                        count_reg     <= '0;
                        prod_reg      <= '0;
                        mcand_reg     <= {{WIDTH{1'b0}}, abs_a};
                        mplier_reg    <= abs_b;
                        rem_reg       <= '0;
                        quot_reg      <= abs_a;
                        divisor_reg   <= abs_b;
                        if (in_div_zero) begin
                            // Short path straight to DONE with a zero result.
                            result_reg <= '0;
                            dbz_reg    <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    count_reg <= count_reg + CNT_W'(1);
                    if (is_div_reg) begin
                        rem_reg  <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                        quot_reg <= {quot_reg[WIDTH-2:0], rem_ge};
                    end else begin
                        prod_reg   <= prod_reg + addend;
                        mcand_reg  <= {mcand_reg[DW-2:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    // An annul here must leave the previous result visible.
                    if (!annul_i) begin
                        result_reg <= fix_result;
                        dbz_reg    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o      = result_reg;
    assign div_by_zero_o = dbz_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// tb_ex_muldiv_unit
// ----------------------------------------------------------------------------
// Self-checking bench for ex_muldiv_unit (WIDTH=32). Two instances share
// the same stimulus: one with accumulate enabled, one with it disabled.
// Expected results come from a plain-arithmetic reference model.
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [2:0]       op_i;
    logic [W-1:0]     opa_i;
    logic [W-1:0]     opb_i;
    logic [2*W-1:0]   hilo_i;
    logic             annul_i;

    logic             busy_a, stall_a, done_a, dbz_a;
    logic [2*W-1:0]   res_a;
    logic             busy_b, stall_b, done_b, dbz_b;
    logic [2*W-1:0]   res_b;

    int checks = 0;
    int errors = 0;

    logic [63:0] last_a, last_b;
    logic        last_dbz_a, last_dbz_b;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W), .ACC_EN(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .hilo_i        (hilo_i),
        .annul_i       (annul_i),
        .busy_o        (busy_a),
        .stallreq_o    (stall_a),
        .done_o        (done_a),
        .result_o      (res_a),
        .div_by_zero_o (dbz_a)
    );

    ex_muldiv_unit #(.WIDTH(W), .ACC_EN(1'b0)) dut_na (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .hilo_i        (hilo_i),
        .annul_i       (annul_i),
        .busy_o        (busy_b),
        .stallreq_o    (stall_b),
        .done_o        (done_b),
        .result_o      (res_b),
        .div_by_zero_o (dbz_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model: {div_by_zero, result}
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo,
                                          input bit acc_en);
        logic [63:0] a64, b64, p;
        longint      la, lb, q, r;
        if (op[2:1] == 2'b11) begin
            if (b == 32'd0) return {1'b1, 64'd0};
            if (!op[0]) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                q  = la / lb;
                r  = la % lb;
                return {1'b0, r[31:0], q[31:0]};
            end
            return {1'b0, a % b, a / b};
        end
        a64 = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
        b64 = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
        p   = a64 * b64;
        if (acc_en && op[2:1] == 2'b01) p = hilo + p;
        else if (acc_en && op[2:1] == 2'b10) p = hilo - p;
        return {1'b0, p};
    endfunction

    // Runs one complete operation on both instances; called at posedge+1.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, input string tag);
        logic [64:0] ea, eb;
        int          cyc;
        int          lat;
        bit          seen;
        bit          stall_bad;
        ea  = model(op, a, b, hilo, 1'b1);
        eb  = model(op, a, b, hilo, 1'b0);
        lat = ea[64] ? 1 : W + 2;
        op_i = op; opa_i = a; opb_i = b; hilo_i = hilo; start_i = 1'b1;
        #1;
        stall_bad = (stall_a !== 1'b1) || (stall_b !== 1'b1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
            if (done_a === 1'b1) seen = 1'b1;
            else if (stall_a !== 1'b1) stall_bad = 1'b1;
        end
        if (stall_a !== 1'b0 || stall_b !== 1'b0) stall_bad = 1'b1;
        check($sformatf("%s latency", tag), 64'(cyc), 64'(lat));
        check($sformatf("%s done_na", tag), 64'(done_b), 64'd1);
        check($sformatf("%s result", tag), res_a, ea[63:0]);
        check($sformatf("%s result_na", tag), res_b, eb[63:0]);
        check($sformatf("%s dbz", tag), 64'(dbz_a), 64'(ea[64]));
        check($sformatf("%s stall", tag), 64'(stall_bad), 64'd0);
        @(posedge clk); #1;
        check($sformatf("%s done_pulse", tag), 64'(done_a), 64'd0);
        check($sformatf("%s busy_after", tag), 64'(busy_a), 64'd0);
        check($sformatf("%s held", tag), res_a, ea[63:0]);
        last_a = ea[63:0]; last_b = eb[63:0];
        last_dbz_a = ea[64]; last_dbz_b = eb[64];
        $display("op=%0d a=%h b=%h hilo=%h -> %h (na %h) dbz=%0d cyc=%0d",
                 op, a, b, hilo, res_a, res_b, dbz_a, cyc);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int          cyc;
        int          dones;
        bit          seen;
        logic [63:0] first_res;
        int          first_cyc;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        op_i = 3'd0; opa_i = '0; opb_i = '0; hilo_i = '0;
        last_a = '0; last_b = '0; last_dbz_a = 1'b0; last_dbz_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", res_a, 64'd0);
        check("reset done", 64'(done_a), 64'd0);
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset dbz", 64'(dbz_a), 64'd0);
        check("reset stall", 64'(stall_a), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 64'd0, "mult_neg");
        check("mult_neg exact", res_a, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, "multu_max");
        check("multu_max exact", res_a, 64'hFFFF_FFFE_0000_0001);
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, "mult_m1");
        run_op(3'b010, 32'd3, 32'd7, 64'h10, "madd");
        check("madd exact", res_a, 64'h25);
        run_op(3'b100, 32'd3, 32'd7, 64'h10, "msub");
        check("msub exact", res_a, 64'hFFFF_FFFF_FFFF_FFFB);
        check("msub noacc exact", res_b, 64'h15);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 64'd0, "div_neg");
        check("div_neg exact", res_a, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, "div_wrap");
        run_op(3'b111, 32'd7, 32'd0, 64'd0, "divu_zero");
        run_op(3'b110, 32'h8000_0000, 32'd0, 64'd0, "div_zero");
        run_op(3'b111, 32'd100, 32'd7, 64'd0, "divu_ok");

        // Annul during a divide in cycle 10
        op_i = 3'b111; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_a === 1'b1) seen = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul no_done_before", 64'(seen), 64'd0);
        check("annul busy", 64'(busy_a), 64'd0);
        check("annul done", 64'(done_a), 64'd0);
        check("annul result", res_a, last_a);
        check("annul dbz", 64'(dbz_a), 64'(last_dbz_a));
        run_op(3'b001, 32'd5, 32'd6, 64'd0, "after_annul");
        check("after_annul exact", res_a, 64'h1E);

        // start_i together with annul_i in IDLE is dropped
        op_i = 3'b000; opa_i = 32'd9; opb_i = 32'd9; start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("start_annul stall", 64'(stall_a), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul busy", 64'(busy_a), 64'd0);

        // start_i pulsed during CALC is ignored
        op_i = 3'b000; opa_i = 32'hFFFF_FFF0; opb_i = 32'd3; hilo_i = '0; start_i = 1'b1;
        dones = 0; first_cyc = 0; first_res = '0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (i == 5) begin
                op_i = 3'b001; opa_i = 32'd2; opb_i = 32'd2; start_i = 1'b1;
            end
            if (done_a === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    first_cyc = i;
                    first_res = res_a;
                end
            end
        end
        check("ignore_start dones", 64'(dones), 64'd1);
        check("ignore_start latency", 64'(first_cyc), 64'(W + 2));
        check("ignore_start result", first_res, 64'hFFFF_FFFF_FFFF_FFD0);

        // rst in cycle 5 of a MULT
        op_i = 3'b000; opa_i = 32'd11; opb_i = 32'd13; start_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst result", res_a, 64'd0);
        check("midrst done", 64'(done_a), 64'd0);
        check("midrst busy", 64'(busy_a), 64'd0);
        check("midrst dbz", 64'(dbz_a), 64'd0);
        check("midrst stall", 64'(stall_a), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            logic [63:0] rh;
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            rh  = {$urandom, $urandom};
            run_op(rop, ra, rb, rh, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
